// File: rtl/block_addr_sequencer_if.sv
// Purpose: request/address bus between the cache controller, the burst sequencer
//          and the memory port.
// Signals:
//   reqValid/reqReady            burst request handshake
//   reqTag/reqIndex/reqOffset    block tag, set index, critical-word offset
//   abort                        cancel the burst in progress
//   addrValid/addrReady          word-address handshake toward memory
//   addr/addrLast                {tag,index,offset} word address, final-beat flag
//   busy                         burst in progress
// Modports: slave = sequencer side, master = controller/memory side.
interface block_addr_sequencer_if #(
  parameter int unsigned addrSize = 30,
  parameter int unsigned offset   = 10,
  parameter int unsigned index    = 10,
  parameter int unsigned tag      = 10
);
  logic                reqValid;
  logic                reqReady;
  logic [tag-1:0]      reqTag;
  logic [index-1:0]    reqIndex;
  logic [offset-1:0]   reqOffset;
  logic                abort;
  logic                addrValid;
  logic                addrReady;
  logic [addrSize-1:0] addr;
  logic                addrLast;
  logic                busy;

  modport slave (
    input  reqValid, reqTag, reqIndex, reqOffset, abort, addrReady,
    output reqReady, addrValid, addr, addrLast, busy
  );

  modport master (
    output reqValid, reqTag, reqIndex, reqOffset, abort, addrReady,
    input  reqReady, addrValid, addr, addrLast, busy
  );
endinterface

// File: rtl/block_addr_sequencer.sv
// Purpose: recompose {tag,index,offset} into word addresses and sequence one
//          cache-block burst, critical word first, wrapping modulo block size.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    block_addr_sequencer_if.slave (request in, address stream out)
module block_addr_sequencer #(
  parameter int unsigned addrSize = 30,
  parameter int unsigned offset   = 10,
  parameter int unsigned index    = 10,
  parameter int unsigned tag      = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  block_addr_sequencer_if.slave  bus
);

  // Address fields must tile the full word address exactly.
  if (tag + index + offset != addrSize) begin : g_cfg_err
    $error("block_addr_sequencer: tag+index+offset must equal addrSize");
  end
  if (offset == 0) begin : g_off_err
    $error("block_addr_sequencer: offset width must be non-zero");
  end

  localparam logic [offset-1:0] LAST_BEAT = '1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t              r_state, w_state;
  logic [tag-1:0]      r_tag, w_tag;
  logic [index-1:0]    r_index, w_index;
  logic [offset-1:0]   r_off, w_off;
  logic [offset-1:0]   r_beat, w_beat;
  logic                r_addr_valid, w_addr_valid;
  logic                r_addr_last, w_addr_last;
  logic                r_busy, w_busy;
  logic                r_req_ready, w_req_ready;
  logic                w_go_idle;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_tag        <= '0;
      r_index      <= '0;
      r_off        <= '0;
      r_beat       <= '0;
      r_addr_valid <= 1'b0;
      r_addr_last  <= 1'b0;
      r_busy       <= 1'b0;
      r_req_ready  <= 1'b1;
    end else begin
      r_state      <= w_state;
      r_tag        <= w_tag;
      r_index      <= w_index;
      r_off        <= w_off;
      r_beat       <= w_beat;
      r_addr_valid <= w_addr_valid;
      r_addr_last  <= w_addr_last;
      r_busy       <= w_busy;
      r_req_ready  <= w_req_ready;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state      = r_state;
    w_tag        = r_tag;
    w_index      = r_index;
    w_off        = r_off;
    w_beat       = r_beat;
    w_addr_valid = r_addr_valid;
    w_addr_last  = r_addr_last;
    w_busy       = r_busy;
    w_req_ready  = r_req_ready;
    w_go_idle    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.reqValid) begin
          w_state      = S_BURST;
          w_tag        = bus.reqTag;
          w_index      = bus.reqIndex;
          w_off        = bus.reqOffset;
          w_beat       = '0;
          w_addr_valid = 1'b1;
          w_addr_last  = 1'b0;
          w_busy       = 1'b1;
          w_req_ready  = 1'b0;
        end
      end
      S_BURST: begin
        // Abort wins; a beat handshaking in the same cycle is simply not followed.
        if (bus.abort) begin
          w_go_idle = 1'b1;
        end else if (bus.addrReady) begin
          if (r_beat == LAST_BEAT) begin
            w_go_idle = 1'b1;
          end else begin
            // Offset wraps inside its own field; carry never reaches index.
            w_off       = r_off + offset'(1);
            w_beat      = r_beat + offset'(1);
            w_addr_last = (w_beat == LAST_BEAT);
          end
        end
      end
      default: w_go_idle = 1'b1;
    endcase

    if (w_go_idle) begin
      w_state      = S_IDLE;
      w_addr_valid = 1'b0;
      w_addr_last  = 1'b0;
      w_busy       = 1'b0;
      w_req_ready  = 1'b1;
    end
  end

  assign bus.reqReady  = r_req_ready;
  assign bus.addrValid = r_addr_valid;
  assign bus.addrLast  = r_addr_last;
  assign bus.busy      = r_busy;
  assign bus.addr      = {r_tag, r_index, r_off};

endmodule
